// File: rtl/alu_pkg.sv
// Shared types for the ALU execution controller: opcodes, FSM states, flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_INC  = 3'd5,
    OP_MOVA = 3'd6,
    OP_MOVB = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus {overflow, negative, zero}. Overflow is only
// meaningful for ADD/SUB and reads 0 for everything else, INC included.
module alu
  import alu_pkg::*;
#(
  parameter int BW = 16
) (
  input  alu_op_e        op,
  input  logic [BW-1:0]  a,
  input  logic [BW-1:0]  b,
  output logic [BW-1:0]  y,
  output logic [2:0]     flags
);

  logic ovf;

  // operation select and signed-overflow detection
  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = a + b;
        ovf = (a[BW-1] == b[BW-1]) && (y[BW-1] != a[BW-1]);
      end
      OP_SUB: begin
        y   = a - b;
        ovf = (a[BW-1] != b[BW-1]) && (y[BW-1] != a[BW-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_INC:  y = a + {{(BW-1){1'b0}}, 1'b1};
      OP_MOVA: y = a;
      OP_MOVB: y = b;
      default: y = '0;
    endcase
  end

  // pack flags into their shared bit positions
  always_comb begin
    flags            = 3'b000;
    flags[FLAG_OVF]  = ovf;
    flags[FLAG_NEG]  = y[BW-1];
    flags[FLAG_ZERO] = (y == '0);
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU execution controller: 8-entry register file, 3-cycle accept/execute/writeback FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a new instruction (instr_ready high)
//   ST_EXEC | operands latched, ALU result captured into res_* at exit
//   ST_WB   | res_valid high, r[rd] written at exit
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           instr_opcode,
  input  logic [2:0]           instr_rd,
  input  logic [2:0]           instr_ra,
  input  logic [2:0]           instr_rb,
  input  logic                 ld_en,
  input  logic [2:0]           ld_addr,
  input  logic [BW-1:0]        ld_data,
  output logic                 res_valid,
  output logic signed [BW-1:0] res_data,
  output logic [2:0]           res_flags,
  output logic                 busy
);

  state_e        state;
  alu_op_e       opcode_q;
  logic [2:0]    rd_q;
  logic [BW-1:0] op_a;
  logic [BW-1:0] op_b;
  logic [BW-1:0] regs [8];
  logic [BW-1:0] alu_y;
  logic [2:0]    alu_flags;
  logic          accept;

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign res_valid   = (state == ST_WB);
  assign busy        = (state != ST_IDLE);

  alu #(.BW(BW)) u_alu (
    .op    (opcode_q),
    .a     (op_a),
    .b     (op_b),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // state sequencing: IDLE -> EXEC on accept, then EXEC -> WB -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= ST_EXEC;
        ST_EXEC: state <= ST_WB;
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // instruction capture; operands read from pre-edge register contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= OP_ADD;
      rd_q     <= 3'd0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (accept) begin
      opcode_q <= alu_op_e'(instr_opcode);
      rd_q     <= instr_rd;
      op_a     <= regs[instr_ra];
      op_b     <= regs[instr_rb];
    end
  end

  // result/flags capture, only on the EXEC -> WB edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_flags <= 3'b000;
    end else if (state == ST_EXEC) begin
      res_data  <= alu_y;
      res_flags <= alu_flags;
    end
  end

  // register file: direct loads any time, writeback placed last so it wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      if (state == ST_WB) regs[rd_q] <= res_data;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: hand-computed vectors checked with immediate assertions.
module tb_alu_exec_ctrl;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, INC = 3'd5, MOVA = 3'd6, MOVB = 3'd7;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [2:0]         instr_opcode = 3'd0;
  logic [2:0]         instr_rd = 3'd0;
  logic [2:0]         instr_ra = 3'd0;
  logic [2:0]         instr_rb = 3'd0;
  logic               ld_en = 1'b0;
  logic [2:0]         ld_addr = 3'd0;
  logic [15:0]        ld_data = 16'h0;
  logic               res_valid;
  logic signed [15:0] res_data;
  logic [2:0]         res_flags;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  alu_exec_ctrl #(.BW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_ra     (instr_ra),
    .instr_rb     (instr_rb),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Offer one instruction, then check the EXEC/WB/IDLE timeline. Optionally
  // fires a direct load during WB so it lands on the writeback edge.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] exp_d, input logic [2:0] exp_f,
                       input bit ld_at_wb, input logic [2:0] la, input logic [15:0] ldd);
    int n;
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".ready"}, {15'd0, instr_ready}, 16'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".exec_valid"}, {15'd0, res_valid}, 16'd0);
    @(negedge clk);
    chk({tag, ".wb_valid"}, {15'd0, res_valid}, 16'd1);
    chk({tag, ".data"}, res_data, exp_d);
    chk({tag, ".flags"}, {13'd0, res_flags}, {13'd0, exp_f});
    if (ld_at_wb) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_valid"}, {15'd0, res_valid}, 16'd0);
    chk({tag, ".idle_ready"}, {15'd0, instr_ready}, 16'd1);
  endtask

  initial begin
    int c0;
    int n;
    // reset state
    #12;
    chk("rst.ready", {15'd0, instr_ready}, 16'd1);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    chk("rst.valid", {15'd0, res_valid}, 16'd0);
    chk("rst.data", res_data, 16'h0000);
    chk("rst.flags", {13'd0, res_flags}, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // ADD overflow into sign bit
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    issue("add", ADD, 3'd3, 3'd1, 3'd2, 16'h8000, 3'b110, 0, 3'd0, 16'h0);
    issue("rd_r3", MOVA, 3'd3, 3'd3, 3'd0, 16'h8000, 3'b010, 0, 3'd0, 16'h0);

    // zero results
    issue("sub0", SUB, 3'd4, 3'd2, 3'd2, 16'h0000, 3'b001, 0, 3'd0, 16'h0);
    issue("xor0", XOR_, 3'd7, 3'd1, 3'd1, 16'h0000, 3'b001, 0, 3'd0, 16'h0);

    // INC never flags overflow
    issue("inc", INC, 3'd5, 3'd1, 3'd0, 16'h8000, 3'b010, 0, 3'd0, 16'h0);

    // logic ops, MOVB, SUB overflow, ADD wrap to zero
    load(3'd6, 16'hF0F0);
    issue("and", AND_, 3'd7, 3'd1, 3'd6, 16'h70F0, 3'b000, 0, 3'd0, 16'h0);
    issue("or", OR_, 3'd7, 3'd1, 3'd6, 16'hFFFF, 3'b010, 0, 3'd0, 16'h0);
    issue("movb", MOVB, 3'd7, 3'd0, 3'd2, 16'h0001, 3'b000, 0, 3'd0, 16'h0);
    issue("subovf", SUB, 3'd7, 3'd3, 3'd2, 16'h7FFF, 3'b100, 0, 3'd0, 16'h0);
    issue("addwrap", ADD, 3'd7, 3'd3, 3'd3, 16'h0000, 3'b101, 0, 3'd0, 16'h0);

    // back-to-back with instr_valid held: ADD r5=r1+r2 then dependent MOVA r6=r5
    load(3'd5, 16'h0000);
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = ADD; instr_rd = 3'd5; instr_ra = 3'd1; instr_rb = 3'd2;
    @(posedge clk); #1;
    c0 = cyc;
    instr_opcode = MOVA; instr_rd = 3'd6; instr_ra = 3'd5; instr_rb = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b.1.valid", {15'd0, res_valid}, 16'd1);
    chk("b2b.1.data", res_data, 16'h8000);
    n = 0;
    while (!(instr_ready && instr_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("b2b.gap", 16'(cyc - c0), 16'd3);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b.2.valid", {15'd0, res_valid}, 16'd1);
    chk("b2b.2.data", res_data, 16'h8000);
    chk("b2b.2.flags", {13'd0, res_flags}, 16'd2);
    @(negedge clk);
    @(negedge clk);

    // reset during EXEC aborts the instruction; loads are ignored while in reset
    instr_valid = 1'b1; instr_opcode = ADD; instr_rd = 3'd3; instr_ra = 3'd1; instr_rb = 3'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h5555;
    #1;
    chk("arst.busy", {15'd0, busy}, 16'd0);
    chk("arst.ready", {15'd0, instr_ready}, 16'd1);
    chk("arst.flags", {13'd0, res_flags}, 16'd0);
    @(posedge clk); #1;
    chk("arst.valid", {15'd0, res_valid}, 16'd0);
    @(negedge clk);
    ld_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.post_valid", {15'd0, res_valid}, 16'd0);
    chk("arst.post_ready", {15'd0, instr_ready}, 16'd1);
    issue("arst.r3", MOVA, 3'd3, 3'd3, 3'd0, 16'h0000, 3'b001, 0, 3'd0, 16'h0);
    issue("arst.r1", MOVA, 3'd1, 3'd1, 3'd0, 16'h0000, 3'b001, 0, 3'd0, 16'h0);

    // writeback beats a same-edge direct load to the same register
    load(3'd1, 16'h0011);
    load(3'd2, 16'h0022);
    issue("wbwin", ADD, 3'd4, 3'd1, 3'd2, 16'h0033, 3'b000, 1, 3'd4, 16'h1234);
    issue("wbwin.r4", MOVA, 3'd4, 3'd4, 3'd0, 16'h0033, 3'b000, 0, 3'd0, 16'h0);

    // different targets on the writeback edge both land
    issue("both", ADD, 3'd4, 3'd1, 3'd2, 16'h0033, 3'b000, 1, 3'd7, 16'h8ABC);
    issue("both.r7", MOVA, 3'd7, 3'd7, 3'd0, 16'h8ABC, 3'b010, 0, 3'd0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
